// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single layout, significand widths and the
// mantissa multiplier state encoding.
package fpu_pkg;
    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 23;
    localparam int MANT_W    = 24;
    localparam int PROD_W    = 48;
    localparam logic [FP_EXP_W-1:0] EXP_ALL_ONES = 8'hFF;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } fmm_state_e;
endpackage

// File: rtl/fpu_mant_mult_if.sv
// Issue/result bundle between the FP execute issuer and the mantissa multiplier.
interface fpu_mant_mult_if;
    import fpu_pkg::*;

    logic [31:0]       opa;
    logic [31:0]       opb;
    logic              start;
    logic              flush;
    logic [PROD_W-1:0] mult_result;
    logic              done;
    logic              busy;

    modport master (
        output opa, opb, start, flush,
        input  mult_result, done, busy
    );

    modport slave (
        input  opa, opb, start, flush,
        output mult_result, done, busy
    );
endinterface

// File: rtl/fpu_unpack.sv
// Combinational IEEE-754 single unpack: significand with hidden bit and
// zero/special classification. Shared with later FPU stages.
module fpu_unpack
    import fpu_pkg::*;
(
    input  fp32_t             op,
    output logic [MANT_W-1:0] mant,
    output logic              is_zero,
    output logic              is_special
);
    logic hidden;
    logic unused_sign;

    // Subnormals carry a zero hidden bit.
    assign hidden      = |op.exp;
    assign mant        = {hidden, op.frac};
    assign is_zero     = !hidden && (op.frac == '0);
    assign is_special  = is_zero || (op.exp == EXP_ALL_ONES);
    assign unused_sign = op.sign;
endmodule

// File: rtl/fpu_mant_mult.sv
// Iterative 24x24 -> 48 unsigned significand multiplier retiring RADIX_BITS
// multiplier bits per cycle; special operands bypass with a zero product.
module fpu_mant_mult
    import fpu_pkg::*;
#(
    parameter int RADIX_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    fpu_mant_mult_if.slave  bus
);
    localparam int N     = MANT_W / RADIX_BITS;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    fmm_state_e        state;
    logic [PROD_W-1:0] mcand;
    logic [MANT_W-1:0] mplier;
    logic [PROD_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic [PROD_W-1:0] result;
    logic              done_r;
    logic              busy_r;

    logic [MANT_W-1:0] mant_a, mant_b;
    logic              zero_a, zero_b, spec_a, spec_b;
    logic              special;
    logic [PROD_W-1:0] pp;
    logic              unused_zero;

    fpu_unpack u_unpack_a (
        .op         (fp32_t'(bus.opa)),
        .mant       (mant_a),
        .is_zero    (zero_a),
        .is_special (spec_a)
    );

    fpu_unpack u_unpack_b (
        .op         (fp32_t'(bus.opb)),
        .mant       (mant_b),
        .is_zero    (zero_b),
        .is_special (spec_b)
    );

    assign special     = spec_a | spec_b;
    assign unused_zero = zero_a ^ zero_b;

    // The multiplicand is pre-shifted each step, so each partial product
    // lands at its final weight without a variable shifter.
    assign pp = mcand * PROD_W'(mplier[RADIX_BITS-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        busy_r <= 1'b1;
                        if (special) begin
                            result <= '0;
                            done_r <= 1'b1;
                            state  <= DONE;
                        end else begin
                            mcand  <= PROD_W'(mant_a);
                            mplier <= mant_b;
                            acc    <= '0;
                            cnt    <= '0;
                            state  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (bus.flush) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end else begin
                        acc    <= acc + pp;
                        mcand  <= mcand << RADIX_BITS;
                        mplier <= mplier >> RADIX_BITS;
                        cnt    <= cnt + 1'b1;
                        if (cnt == CNT_W'(N - 1)) begin
                            result <= acc + pp;
                            done_r <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    // A flush arriving in the done cycle still kills the pulse.
    assign bus.done        = done_r & ~bus.flush;
    assign bus.busy        = busy_r;
    assign bus.mult_result = result;
endmodule

// File: tb/tb_fpu_mant_mult.sv
// Bench for fpu_mant_mult: one instance per legal radix driven in lockstep,
// checked every cycle against a latency/product model plus pinned literals.
module tb_fpu_mant_mult;
    localparam int NR = 6;

    function automatic int radix_of(int k);
        return (k == 4) ? 6 : (k == 5) ? 8 : k + 1;
    endfunction

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] opa   = '0;
    logic [31:0] opb   = '0;
    int          cyc   = 0;

    logic [NR-1:0] done_v;
    logic [NR-1:0] busy_v;
    logic [47:0]   res_v [NR];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < NR; k++) begin : g_r
        localparam int R = (k == 4) ? 6 : (k == 5) ? 8 : k + 1;
        fpu_mant_mult_if ifs ();
        assign ifs.opa   = opa;
        assign ifs.opb   = opb;
        assign ifs.start = start;
        assign ifs.flush = flush;
        assign done_v[k] = ifs.done;
        assign busy_v[k] = ifs.busy;
        assign res_v[k]  = ifs.mult_result;
        fpu_mant_mult #(.RADIX_BITS(R)) dut (
            .clk (clk),
            .rst (rst),
            .bus (ifs)
        );
    end

    // Reference: plain integer product of the unpacked significands.
    function automatic logic is_spec(logic [31:0] a);
        return (a[30:0] == 31'd0) || (a[30:23] == 8'hFF);
    endfunction

    function automatic logic [47:0] ref_prod(logic [31:0] a, logic [31:0] b);
        logic [23:0] ma;
        logic [23:0] mb;
        ma = {|a[30:23], a[22:0]};
        mb = {|b[30:23], b[22:0]};
        if (is_spec(a) || is_spec(b)) return 48'd0;
        return {24'd0, ma} * {24'd0, mb};
    endfunction

    // Model state per instance, in absolute cycle numbers: op accepted at
    // edge acc_e, busy through cycle busy_end, done pulse in cycle exp_done.
    int          acc_e    [NR];
    int          busy_end [NR];
    int          exp_done [NR];
    logic [47:0] exp_res  [NR];
    logic [47:0] cur_res  [NR];

    always @(posedge clk) begin
        for (int k = 0; k < NR; k++) begin
            int          ae, be, ed, lat;
            logic [47:0] er, cr;
            logic        busy_now;
            ae = acc_e[k]; be = busy_end[k]; ed = exp_done[k];
            er = exp_res[k]; cr = cur_res[k];
            if (rst) begin
                ae = -1; be = -1; ed = -1; er = '0; cr = '0;
            end else begin
                busy_now = (cyc > ae) && (cyc <= be);
                if (flush && busy_now && cyc < ed) begin
                    ed = -1;
                    be = cyc;
                end else if (!busy_now && start && !flush) begin
                    lat = (is_spec(opa) || is_spec(opb)) ? 1 : 24 / radix_of(k) + 1;
                    ae  = cyc;
                    ed  = cyc + lat;
                    be  = cyc + lat;
                    er  = ref_prod(opa, opb);
                end
                if (ed == cyc + 1) cr = er;
            end
            acc_e[k]    <= ae;
            busy_end[k] <= be;
            exp_done[k] <= ed;
            exp_res[k]  <= er;
            cur_res[k]  <= cr;
        end
    end

    typedef struct {
        int          k;
        int          at;
        logic        done;
        logic        busy;
        logic        use_res;
        logic [47:0] res;
    } pin_t;
    pin_t pins[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(string nm, int k, logic [47:0] act, logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s r=%0d cyc=%0d got=%h want=%h", nm, radix_of(k), cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int k = 0; k < NR; k++) begin
                chk("done", k, 48'(done_v[k]), 48'((cyc == exp_done[k]) && !flush));
                chk("busy", k, 48'(busy_v[k]), 48'((cyc > acc_e[k]) && (cyc <= busy_end[k])));
                chk("result", k, res_v[k], cur_res[k]);
            end
            while (pins.size() != 0 && pins[0].at <= cyc) begin
                pin_t p;
                p = pins.pop_front();
                chk("pin_cycle", p.k, 48'(cyc), 48'(p.at));
                chk("pin_done", p.k, 48'(done_v[p.k]), 48'(p.done));
                chk("pin_busy", p.k, 48'(busy_v[p.k]), 48'(p.busy));
                if (p.use_res) chk("pin_result", p.k, res_v[p.k], p.res);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(int c);
        while (cyc < c) tick();
    endtask

    task automatic pin(int k, int at, logic d, logic b, logic u, logic [47:0] r);
        pin_t p;
        p.k = k; p.at = at; p.done = d; p.busy = b; p.use_res = u; p.res = r;
        pins.push_back(p);
    endtask

    task automatic op(logic [31:0] a, logic [31:0] b);
        opa = a; opb = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [31:0] rnd_op();
        int sel;
        sel = $urandom_range(0, 15);
        if (sel == 0) begin
            case ($urandom_range(0, 3))
                0:       return 32'h0000_0000;
                1:       return 32'h8000_0000;
                2:       return 32'h7F80_0000;
                default: return 32'h7FC0_0001;
            endcase
        end
        if (sel <= 3) return {1'($urandom_range(0, 1)), 8'h00, 23'($urandom)};
        return $urandom;
    endfunction

    initial begin
        int c;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // 1.0 * 1.0
        c = cyc;
        pin(5, c + 4,  1, 1, 1, 48'h4000_0000_0000);
        pin(1, c + 13, 1, 1, 1, 48'h4000_0000_0000);
        pin(0, c + 24, 0, 1, 0, 48'h0);
        pin(0, c + 25, 1, 1, 1, 48'h4000_0000_0000);
        op(32'h3F80_0000, 32'h3F80_0000);
        wait_until(c + 28);

        // largest significands
        c = cyc;
        pin(5, c + 4,  1, 1, 1, 48'hFFFF_FE00_0001);
        pin(1, c + 13, 1, 1, 1, 48'hFFFF_FE00_0001);
        pin(0, c + 25, 1, 1, 1, 48'hFFFF_FE00_0001);
        op(32'h3FFF_FFFF, 32'h3FFF_FFFF);
        wait_until(c + 28);

        // smallest subnormal times 1.0
        c = cyc;
        pin(0, c + 25, 1, 1, 1, 48'h0000_0080_0000);
        op(32'h0000_0001, 32'h3F80_0000);
        wait_until(c + 28);

        // special operands take the one-cycle path with a zero product
        c = cyc;
        pin(0, c + 1, 1, 1, 1, 48'h0);
        pin(5, c + 1, 1, 1, 1, 48'h0);
        op(32'h0000_0000, 32'h3F80_0000);
        wait_until(c + 3);
        c = cyc;
        pin(0, c + 1, 1, 1, 1, 48'h0);
        op(32'h7F80_0000, 32'h3F80_0000);
        wait_until(c + 3);
        c = cyc;
        pin(0, c + 1, 1, 1, 1, 48'h0);
        pin(0, c + 2, 0, 0, 1, 48'h0);
        op(32'h4000_0000, 32'h7FC0_0000);
        wait_until(c + 3);

        // start re-pulsed while busy is ignored
        c = cyc;
        pin(0, c + 25, 1, 1, 1, 48'h6000_0000_0000);
        op(32'h3FC0_0000, 32'h4000_0000);
        wait_until(c + 5);
        op(32'h3F80_0000, 32'h3F80_0000);
        wait_until(c + 28);

        // flush mid-op: no done, old result kept, next op completes
        c = cyc;
        pin(0, c + 11, 0, 0, 1, 48'h6000_0000_0000);
        pin(0, c + 25, 0, 0, 1, 48'h6000_0000_0000);
        op(32'h3FFF_FFFF, 32'h3F80_0000);
        wait_until(c + 10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_until(c + 27);
        c = cyc;
        pin(0, c + 25, 1, 1, 1, 48'h7FFF_FF80_0000);
        op(32'h3FFF_FFFF, 32'h3F80_0000);
        wait_until(c + 28);

        // reset mid-op
        c = cyc;
        pin(0, c + 13, 0, 0, 1, 48'h0);
        pin(0, c + 25, 0, 0, 1, 48'h0);
        op(32'h4040_0000, 32'h40A0_0000);
        wait_until(c + 12);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_until(c + 28);

        // back-to-back: second start in the cycle after done
        c = cyc;
        pin(0, c + 25, 1, 1, 1, 48'h7800_0000_0000);
        pin(0, c + 26, 0, 0, 1, 48'h7800_0000_0000);
        pin(0, c + 51, 1, 1, 1, 48'h2000_0040_0000);
        op(32'h4040_0000, 32'h40A0_0000);
        wait_until(c + 26);
        op(32'h0040_0000, 32'h3F80_0001);
        wait_until(c + 55);

        // random operands, start offered most cycles
        repeat (3000) begin
            opa   = rnd_op();
            opb   = rnd_op();
            start = ($urandom_range(0, 3) != 0);
            tick();
        end
        start = 1'b0;
        repeat (30) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
